// File: rtl/rv32_pkg.sv
// Shared encodings for the MEM stage: load/store widths, FSM states and byte-enable patterns.
package rv32_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ready bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_stage_load_align_ext.sv
// Selects the addressed byte/halfword from a captured read word and sign/zero-extends it.
module load_align_ext
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rw_type,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (rw_type)
            RW_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            RW_H:    load_data = {{16{half_sel[15]}}, half_sel};
            RW_BU:   load_data = {24'h000000, byte_sel};
            RW_HU:   load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the req/ready bus, stalls while outstanding,
// and selects the write-back value (LUI immediate, aligned load data or ALU result).
module mem_access_stage
    import rv32_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                aluout_MEM,
    input  logic [31:0]                read2_MEM,
    input  logic [31:0]                imm_MEM,
    input  logic [4:0]                 rd_MEM,
    input  logic                       RegWrite_MEM,
    input  logic                       MemRead_MEM,
    input  logic                       MemWrite_MEM,
    input  logic                       MemtoReg_MEM,
    input  logic                       lui_MEM,
    input  logic [2:0]                 RW_type_MEM,
    mem_access_stage_if.master         dmem,
    output logic                       mem_stall,
    output logic [31:0]                wb_data,
    output logic                       RegWrite_WB_o,
    output logic [4:0]                 rd_WB_o,
    output logic                       misalign,
    output logic                       bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    mem_state_e  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [31:0] rdata_q_reg, rdata_q_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  be_reg, be_next;

    logic        access;
    logic        addr_misaligned;
    logic [31:0] store_wdata;
    logic [3:0]  store_be;
    logic [31:0] load_ext;

    assign access = MemRead_MEM | MemWrite_MEM;

    always_comb begin
        addr_misaligned = 1'b0;
        case (RW_type_MEM)
            RW_H, RW_HU: addr_misaligned = aluout_MEM[0];
            RW_W:        addr_misaligned = (aluout_MEM[1:0] != 2'b00);
            default:     addr_misaligned = 1'b0;
        endcase
    end

    // Lane replication lets the memory pick bytes purely by byte enable.
    always_comb begin
        store_wdata = read2_MEM;
        store_be    = BE_ALL;
        case (RW_type_MEM[1:0])
            2'b00: begin
                store_wdata = {4{read2_MEM[7:0]}};
                store_be    = BE_B0 << aluout_MEM[1:0];
            end
            2'b01: begin
                store_wdata = {2{read2_MEM[15:0]}};
                store_be    = aluout_MEM[1] ? BE_HI : BE_LO;
            end
            default: begin
                store_wdata = read2_MEM;
                store_be    = BE_ALL;
            end
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        rdata_q_next = rdata_q_reg;
        req_next     = req_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        be_next      = be_reg;
        mem_stall    = 1'b0;
        misalign     = 1'b0;
        bus_err      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    if (addr_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        req_next   = 1'b1;
                        we_next    = MemWrite_MEM & ~MemRead_MEM;
                        addr_next  = {aluout_MEM[31:2], 2'b00};
                        wdata_next = store_wdata;
                        be_next    = store_be;
                        cnt_next   = '0;
                        mem_stall  = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                cnt_next  = cnt_reg + 1'b1;
                // A ready arriving on the final permitted cycle still completes cleanly.
                if (dmem.dmem_ready) begin
                    rdata_q_next = dmem.dmem_rdata;
                    req_next     = 1'b0;
                    state_next   = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    bus_err    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                err_next   = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            rdata_q_reg <= 32'h0;
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            be_reg      <= BE_NONE;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            rdata_q_reg <= rdata_q_next;
            req_reg     <= req_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            be_reg      <= be_next;
        end
    end

    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;
    assign dmem.dmem_be    = be_reg;

    load_align_ext u_load_align_ext (
        .rdata     (rdata_q_reg),
        .addr_lo   (aluout_MEM[1:0]),
        .rw_type   (RW_type_MEM),
        .load_data (load_ext)
    );

    assign wb_data       = lui_MEM ? imm_MEM : (MemtoReg_MEM ? load_ext : aluout_MEM);
    assign RegWrite_WB_o = RegWrite_MEM & ~misalign & ~((state_reg == ST_DONE) & err_reg);
    assign rd_WB_o       = rd_MEM;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed checks of the MEM stage: store lanes, waited loads, misalignment, timeout, reset, LUI.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] aluout_MEM, read2_MEM, imm_MEM;
    logic [4:0]  rd_MEM;
    logic        RegWrite_MEM, MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, lui_MEM;
    logic [2:0]  RW_type_MEM;
    logic        mem_stall, RegWrite_WB_o, misalign, bus_err;
    logic [31:0] wb_data;
    logic [4:0]  rd_WB_o;

    int errors = 0;
    int checks = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .aluout_MEM    (aluout_MEM),
        .read2_MEM     (read2_MEM),
        .imm_MEM       (imm_MEM),
        .rd_MEM        (rd_MEM),
        .RegWrite_MEM  (RegWrite_MEM),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .MemtoReg_MEM  (MemtoReg_MEM),
        .lui_MEM       (lui_MEM),
        .RW_type_MEM   (RW_type_MEM),
        .dmem          (bus.master),
        .mem_stall     (mem_stall),
        .wb_data       (wb_data),
        .RegWrite_WB_o (RegWrite_WB_o),
        .rd_WB_o       (rd_WB_o),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        MemtoReg_MEM = 1'b0; lui_MEM = 1'b0; RW_type_MEM = 3'b000;
        aluout_MEM = 32'h0; read2_MEM = 32'h0; imm_MEM = 32'h0; rd_MEM = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        clear_ctrl();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_be", bus.dmem_be, 4'h0);
        chk("rst_buserr", bus_err, 0);

        // SW 0x100, zero-wait memory (ready already high in IDLE is ignored)
        tick();
        MemWrite_MEM = 1'b1; RW_type_MEM = 3'b010; aluout_MEM = 32'h100; read2_MEM = 32'hDEADBEEF;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("sw_stall_idle", mem_stall, 1);
        chk("sw_req_before", bus.dmem_req, 0);
        tick();
        @(negedge clk);
        chk("sw_stall_req", mem_stall, 1);
        chk("sw_req", bus.dmem_req, 1);
        chk("sw_we", bus.dmem_we, 1);
        chk("sw_addr", bus.dmem_addr, 32'h100);
        chk("sw_be", bus.dmem_be, 4'hF);
        chk("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("sw_stall_done", mem_stall, 0);
        chk("sw_req_done", bus.dmem_req, 0);
        tick();

        // SB 0x103
        bus.dmem_ready = 1'b0;
        RW_type_MEM = 3'b000; aluout_MEM = 32'h103; read2_MEM = 32'h000000A5;
        @(negedge clk);
        chk("sb_stall_idle", mem_stall, 1);
        tick();
        @(negedge clk);
        chk("sb_be", bus.dmem_be, 4'b1000);
        chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", bus.dmem_addr, 32'h100);
        bus.dmem_ready = 1'b1;
        tick();
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("sb_stall_done", mem_stall, 0);
        tick();

        // LB 0x102 with 3 wait cycles; ready lands exactly on the last permitted cycle
        clear_ctrl();
        MemRead_MEM = 1'b1; RegWrite_MEM = 1'b1; MemtoReg_MEM = 1'b1; rd_MEM = 5'd5;
        RW_type_MEM = 3'b000; aluout_MEM = 32'h102;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("lb_stall_c1", mem_stall, 1);
        tick();
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("lb_stall_wait", mem_stall, 1);
            chk("lb_req_wait", bus.dmem_req, 1);
            chk("lb_we", bus.dmem_we, 0);
            tick();
        end
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h12F03456;
        #1;
        chk("lb_stall_c5", mem_stall, 1);
        chk("lb_no_buserr", bus_err, 0);
        tick();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("lb_stall_done", mem_stall, 0);
        chk("lb_wb", wb_data, 32'hFFFFFFF0);
        chk("lb_regwrite", RegWrite_WB_o, 1);
        chk("lb_rd", rd_WB_o, 5'd5);
        tick();

        // LBU on the same data, zero wait
        RW_type_MEM = 3'b100;
        @(negedge clk);
        chk("lbu_stall_idle", mem_stall, 1);
        tick();
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h12F03456;
        tick();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        chk("lbu_wb", wb_data, 32'h000000F0);
        tick();

        // LH 0x201 misaligned
        RW_type_MEM = 3'b001; aluout_MEM = 32'h201;
        @(negedge clk);
        chk("lh_misalign", misalign, 1);
        chk("lh_regwrite", RegWrite_WB_o, 0);
        chk("lh_stall", mem_stall, 0);
        tick();
        @(negedge clk);
        chk("lh_req", bus.dmem_req, 0);
        tick();

        // LW 0x300, memory never ready: timeout after 4 REQ cycles
        RW_type_MEM = 3'b010; aluout_MEM = 32'h300;
        @(negedge clk);
        chk("lw_misalign", misalign, 0);
        tick();
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("lw_buserr_early", bus_err, 0);
            tick();
        end
        @(negedge clk);
        chk("lw_buserr", bus_err, 1);
        chk("lw_stall_last", mem_stall, 1);
        tick();
        @(negedge clk);
        chk("lw_buserr_done", bus_err, 0);
        chk("lw_regwrite_done", RegWrite_WB_o, 0);
        chk("lw_stall_done", mem_stall, 0);
        chk("lw_req_done", bus.dmem_req, 0);
        tick();
        clear_ctrl();
        RegWrite_MEM = 1'b1; aluout_MEM = 32'hCAFEF00D;
        @(negedge clk);
        chk("alu_regwrite", RegWrite_WB_o, 1);
        chk("alu_wb", wb_data, 32'hCAFEF00D);
        chk("alu_stall", mem_stall, 0);
        tick();

        // Reset while in REQ, then a late ready
        clear_ctrl();
        MemRead_MEM = 1'b1; RW_type_MEM = 3'b010; aluout_MEM = 32'h400;
        tick();
        @(negedge clk);
        chk("rstreq_req", bus.dmem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_ctrl();
        @(negedge clk);
        chk("rstreq_req_after", bus.dmem_req, 0);
        chk("rstreq_stall", mem_stall, 0);
        bus.dmem_ready = 1'b1;
        tick();
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_req", bus.dmem_req, 0);
        chk("late_ready_stall", mem_stall, 0);

        // LUI
        lui_MEM = 1'b1; imm_MEM = 32'h12345000; RegWrite_MEM = 1'b1; rd_MEM = 5'd7;
        aluout_MEM = 32'h55555555;
        #1;
        chk("lui_wb", wb_data, 32'h12345000);
        chk("lui_stall", mem_stall, 0);
        chk("lui_rd", rd_WB_o, 5'd7);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
